timer_arbiter: RTL and testbench

//  Shares one prescaler+delay-counter timer among N_REQ requesters (e.g. FSMs

---
 rtl/timer_arbiter_pkg.sv | 27 ++
 rtl/timer_arbiter_if.sv | 15 +
 rtl/timer_arbiter_tick_gen.sv | 34 +++
 rtl/timer_arbiter.sv | 125 ++++++++++++
 tb/tb_timer_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared types and elaboration helpers for the timer arbiter.
// State encodings, ceil-log2 and prescaler divide derivation.
package timer_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Smallest r with 2**r >= v, never below 1 so it is always usable as a width.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   function automatic int unsigned tick_div(input int unsigned clk_freq,
                                            input int unsigned tick_freq);
      return clk_freq / tick_freq;
   endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between the requesters and the shared timer.
interface timer_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DLY_W = 16
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*DLY_W-1:0] dly;
   logic [N_REQ-1:0]       gnt;
   logic [N_REQ-1:0]       done;
   logic                   busy;
   logic [DLY_W-1:0]       remaining;

   modport master (output req, dly, input gnt, done, busy, remaining);
   modport slave  (input req, dly, output gnt, done, busy, remaining);
endinterface

// File: rtl/timer_arbiter_tick_gen.sv
// Prescaler: counts clk cycles while enabled and emits a one-cycle tick
// every CLK_FREQ/TICK_FREQ cycles; synchronous clear holds it at zero.
module tick_gen
   import timer_arbiter_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned TICK_FREQ = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, TICK_FREQ);
   localparam int unsigned PW       = clog2(TICK_DIV);

   if (TICK_DIV < 2) begin : g_div_check
      $error("tick_gen: CLK_FREQ/TICK_FREQ must be at least 2");
   end

   logic [PW-1:0] cnt;

   assign tick = en && (cnt == PW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one prescaled delay counter among N_REQ
// requesters; grants, completion pulses and remaining count are registered.
module timer_arbiter
   import timer_arbiter_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned TICK_FREQ = 1000,
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DLY_W     = 16
) (
   input logic             clk,
   input logic             rst,
   timer_arbiter_if.slave  bus
);
   localparam int unsigned      IW  = clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   state_t           state, state_nxt;
   logic [IW-1:0]    idx, idx_nxt, ptr, ptr_nxt, win, cand;
   logic             found;
   logic [DLY_W-1:0] rem_nxt, dly_sel;
   logic [DLY_W-1:0] dly_a [N_REQ];
   logic [N_REQ-1:0] gnt_nxt, done_nxt;
   logic             busy_nxt;
   logic             tick, run_en, pre_clr;

   for (genvar g = 0; g < N_REQ; g++) begin : g_dly
      assign dly_a[g] = bus.dly[g*DLY_W +: DLY_W];
   end

   assign dly_sel = dly_a[idx];
   assign run_en  = (state == ST_RUN);
   // Clear from the next state so the prescaler is already 0 in the first cycle out of RUN.
   assign pre_clr = (state_nxt != ST_RUN);

   tick_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .TICK_FREQ (TICK_FREQ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .en   (run_en),
      .tick (tick)
   );

   always_comb begin
      found = 1'b0;
      win   = ptr;
      cand  = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = IW'((32'(ptr) + i) % N_REQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      ptr_nxt   = ptr;
      rem_nxt   = bus.remaining;
      unique case (state)
         ST_IDLE: begin
            if (found) begin
               idx_nxt   = win;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!bus.req[idx]) begin
               ptr_nxt   = idx;
               rem_nxt   = '0;
               state_nxt = ST_IDLE;
            end else if (dly_sel == '0) begin
               state_nxt = ST_DONE;
            end else begin
               rem_nxt   = dly_sel;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!bus.req[idx]) begin
               ptr_nxt   = idx;
               rem_nxt   = '0;
               state_nxt = ST_IDLE;
            end else if (tick) begin
               rem_nxt = bus.remaining - DLY_W'(1);
               if (bus.remaining == DLY_W'(1)) state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            ptr_nxt   = idx;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
      gnt_nxt  = busy_nxt ? (ONE << idx_nxt) : '0;
      done_nxt = (state_nxt == ST_DONE) ? (ONE << idx_nxt) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         idx           <= '0;
         ptr           <= IW'(N_REQ - 1);
         bus.gnt       <= '0;
         bus.done      <= '0;
         bus.busy      <= 1'b0;
         bus.remaining <= '0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         ptr           <= ptr_nxt;
         bus.gnt       <= gnt_nxt;
         bus.done      <= done_nxt;
         bus.busy      <= busy_nxt;
         bus.remaining <= rem_nxt;
      end
   end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with TICK_DIV=10, four requesters.
module tb_timer_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   timer_arbiter_if #(.N_REQ(4), .DLY_W(16)) bus ();

   timer_arbiter #(
      .CLK_FREQ  (1000),
      .TICK_FREQ (100),
      .N_REQ     (4),
      .DLY_W     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_dly(input int i, input logic [15:0] v);
      bus.dly[i*16 +: 16] = v;
   endtask

   function automatic int enc(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   int first, nd, bad1h;
   int ord [5];
   int at  [5];

   initial begin
      rst     = 1'b1;
      bus.req = '0;
      bus.dly = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt",  bus.gnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rem",  bus.remaining, 0);

      // single requester, delay 3
      rst     = 1'b0;
      bus.req = 4'b0001;
      set_dly(0, 16'd3);
      first = 0; nd = 0;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (k == 1)  chk("t1_gnt", bus.gnt, 4'b0001);
         if (k == 1)  chk("t1_load_rem", bus.remaining, 0);
         if (k == 2)  chk("t1_rem3", bus.remaining, 3);
         if (k == 12) chk("t1_rem2", bus.remaining, 2);
         if (k == 22) chk("t1_rem1", bus.remaining, 1);
         if (k == 32) chk("t1_rem0", bus.remaining, 0);
         if (k == 32) chk("t1_done", bus.done, 4'b0001);
         if (bus.done != 0) begin
            nd++;
            if (first == 0) first = k;
         end
      end
      chk("t1_done_cycle", first, 32);
      chk("t1_done_count", nd, 1);
      bus.req = '0;
      @(negedge clk);
      chk("t1_idle_gnt",  bus.gnt, 0);
      chk("t1_idle_done", bus.done, 0);
      chk("t1_idle_busy", bus.busy, 0);

      // all four requesting, delay 1 each, starting from reset pointer
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) set_dly(i, 16'd1);
      nd = 0; bad1h = 0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if ((bus.gnt & (bus.gnt - 4'd1)) != 0) bad1h++;
         if (bus.done != 0) begin
            if ((bus.done & (bus.done - 4'd1)) != 0) bad1h++;
            if (nd < 5) begin
               ord[nd] = enc(bus.done);
               at[nd]  = k;
            end
            nd++;
            if (nd == 5) bus.req = '0;
         end
      end
      chk("t2_done_count", nd, 5);
      chk("t2_onehot", bad1h, 0);
      chk("t2_ord0", ord[0], 0);
      chk("t2_ord1", ord[1], 1);
      chk("t2_ord2", ord[2], 2);
      chk("t2_ord3", ord[3], 3);
      chk("t2_ord4", ord[4], 0);
      chk("t2_first_at", at[0], 12);
      chk("t2_last_at", at[4], 64);

      // zero delay completes straight out of LOAD
      bus.req = 4'b0100;
      set_dly(2, 16'd0);
      @(negedge clk);
      chk("t3_gnt", bus.gnt, 4'b0100);
      chk("t3_nodone", bus.done, 0);
      @(negedge clk);
      chk("t3_done", bus.done, 4'b0100);
      chk("t3_gnt_done", bus.gnt, 4'b0100);
      bus.req = '0;
      @(negedge clk);
      chk("t3_busy", bus.busy, 0);
      chk("t3_gnt_off", bus.gnt, 0);

      // withdraw after two ticks
      bus.req = 4'b0010;
      set_dly(1, 16'd5);
      nd = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1)  chk("t4_gnt", bus.gnt, 4'b0010);
         if (k == 2)  chk("t4_rem5", bus.remaining, 5);
         if (k == 22) chk("t4_rem3", bus.remaining, 3);
         if (k == 22) bus.req = '0;
         if (k == 23) chk("t4_wd_gnt", bus.gnt, 0);
         if (k == 23) chk("t4_wd_rem", bus.remaining, 0);
         if (k == 23) chk("t4_wd_busy", bus.busy, 0);
         if (bus.done != 0) nd++;
      end
      chk("t4_no_done", nd, 0);
      bus.req = 4'b1111;
      @(negedge clk);
      chk("t4_next_gnt", bus.gnt, 4'b0100);
      bus.req = '0;
      @(negedge clk);
      chk("t4_ld_wd", bus.gnt, 0);

      // reset in the middle of RUN
      bus.req = 4'b0001;
      set_dly(0, 16'd5);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 1)  chk("t5_gnt", bus.gnt, 4'b0001);
         if (k == 13) chk("t5_rem4", bus.remaining, 4);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("t5_gnt_rst",  bus.gnt, 0);
      chk("t5_done_rst", bus.done, 0);
      chk("t5_rem_rst",  bus.remaining, 0);
      chk("t5_busy_rst", bus.busy, 0);
      rst     = 1'b0;
      bus.req = 4'b1111;
      @(negedge clk);
      chk("t5_ptr_reset", bus.gnt, 4'b0001);
      bus.req = '0;
      @(negedge clk);
      chk("t5_wd", bus.gnt, 0);

      // delay change after LOAD is ignored
      bus.req = 4'b0001;
      set_dly(0, 16'd3);
      first = 0;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (k == 5) set_dly(0, 16'd9);
         if (bus.done != 0 && first == 0) first = k;
         if (k == 32) chk("t6_done", bus.done, 4'b0001);
      end
      chk("t6_done_cycle", first, 32);
      bus.req = '0;
      @(negedge clk);

      // full-scale delay decrements without wrap
      bus.req = 4'b0001;
      set_dly(0, 16'hFFFF);
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         if (k == 2)  chk("t6_max", bus.remaining, 16'hFFFF);
         if (k == 12) chk("t6_max_m1", bus.remaining, 16'hFFFE);
         if (k == 22) chk("t6_max_m2", bus.remaining, 16'hFFFD);
      end
      bus.req = '0;
      @(negedge clk);
      chk("t6_wd_gnt", bus.gnt, 0);
      chk("t6_wd_rem", bus.remaining, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
